// File: rtl/gcd_core.sv
// gcd_core: iterative subtractive GCD with a registered A/B compare and a per-run subtraction count.
module gcd_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] iter_cnt,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, it_q, it_d;
  logic             busy_q, done_q, gt_q, eq_q, lt_q;
  logic             stop;
  assign stop = (a_q == '0) || (b_q == '0) || (a_q == b_q);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    it_d    = it_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      a_d     = a_in;
      b_d     = b_in;
      it_d    = '0;
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = DONE;
        res_d   = (a_q == '0) ? b_q : a_q;
      end else begin
        a_d  = (a_q > b_q) ? a_q - b_q : a_q;
        b_d  = (a_q > b_q) ? b_q : b_q - a_q;
        it_d = it_q + WIDTH'(1);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // Flags are computed from next-state values so they line up with the A/B registers they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      it_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      it_q    <= it_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      gt_q    <= (state_d == RUN) && (a_d > b_d);
      eq_q    <= (state_d == RUN) && (a_d == b_d);
      lt_q    <= (state_d == RUN) && (a_d < b_d);
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign iter_cnt = it_q;
  assign gt       = gt_q;
  assign eq       = eq_q;
  assign lt       = lt_q;
endmodule

// File: tb/tb_gcd_core.sv
// tb_gcd_core: directed scoreboard bench for gcd_core; expected results come from a Euclid-based model.
module tb_gcd_core;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, gt, eq, lt;
  logic [W-1:0] result, iter_cnt;
  int checks = 0, errors = 0;
  typedef struct {int res; int it;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  gcd_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .iter_cnt(iter_cnt),
    .gt(gt), .eq(eq), .lt(lt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask
  // Subtraction count equals the sum of Euclid quotients minus the final equal-operands step.
  task automatic push_exp(input int a, input int b);
    exp_t e;
    int x = a, y = b, t;
    e.it = 0;
    if (x != 0 && y != 0) begin
      while (y != 0) begin
        e.it += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      e.it -= 1;
      e.res = x;
    end else e.res = (x == 0) ? y : x;
    sb.push_back(e);
  endtask
  task automatic pop_chk(input int lat);
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("iter_cnt", iter_cnt, e.it);
      chk("latency", lat, e.it + 1);
    end
  endtask
  task automatic run_op(input int a, input int b, input bit poke, output bit lt_seen, output bit eq_seen);
    int lat;
    @(negedge clk);
    chk("idle_done_low", done, 0);
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a_in;
    b_in  = ~b_in;
    chk("busy_after_accept", busy, 1);
    chk("first_cmp", {gt, eq, lt}, (a > b) ? 4 : (a == b) ? 2 : 1);
    lt_seen = lt;
    eq_seen = eq;
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (poke) start = (lat % 5 == 0);
      if (busy) begin
        chk("cmp_onehot", $onehot({gt, eq, lt}), 1);
        lt_seen |= lt;
        eq_seen |= eq;
      end
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_in_done", busy, 0);
    chk("cmp_idle", {gt, eq, lt}, 0);
    pop_chk(lat);
  endtask
  initial begin
    bit ls, es, seen;
    int acc, last, ndone;
    logic prev;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_cmp", {gt, eq, lt}, 0);
    rst_n = 1'b1;
    run_op(12, 8, 1'b0, ls, es);
    chk("lt_seen_12_8", ls, 1);
    chk("eq_seen_12_8", es, 1);
    run_op(9, 9, 1'b0, ls, es);
    chk("eq_seen_9_9", es, 1);
    run_op(0, 5, 1'b0, ls, es);
    run_op(0, 0, 1'b0, ls, es);
    run_op(5, 0, 1'b0, ls, es);
    run_op(255, 1, 1'b1, ls, es);
    run_op(1, 255, 1'b0, ls, es);
    @(negedge clk);
    chk("result_held", result, 1);
    a_in  = 8'd200;
    b_in  = 8'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_iter", iter_cnt, 0);
    chk("midrst_cmp", {gt, eq, lt}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("no_done_after_rst", seen, 0);
    run_op(21, 14, 1'b0, ls, es);
    @(negedge clk);
    a_in  = 8'd6;
    b_in  = 8'd4;
    start = 1'b1;
    prev  = 1'b0;
    acc   = 0;
    last  = -1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy && !prev) begin
        push_exp(6, 4);
        acc = c;
      end
      if (done) begin
        ndone++;
        pop_chk(c - acc);
        if (last >= 0) chk("repeat_period", c - last, 5);
        last = c;
      end
      prev = busy;
    end
    start = 1'b0;
    chk("repeat_count", ndone, 8);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcd_core.md
GCD_CORE -- requirements
Module: gcd_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, request to begin a GCD computation.
REQ-005 SHALL have ports a_in and b_in, input, WIDTH bits each, unsigned operands sampled on the accepting edge.
REQ-006 SHALL have port busy, output, 1 bit, high while the core is iterating.
REQ-007 SHALL have port done, output, 1 bit, one-cycle pulse marking a valid result.
REQ-008 SHALL have port result, output, WIDTH bits, the GCD; holds its value until the next accepted start.
REQ-009 SHALL have port iter_cnt, output, WIDTH bits, the number of subtraction steps taken in the last or current computation.
REQ-010 SHALL have ports gt, eq, lt, output, 1 bit each, the registered compare of the internal A and B registers (A>B, A==B, A<B), exactly one high whenever busy=1.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE; all outputs registered.
REQ-012 SHALL accept start only in IDLE; at the accepting edge, load A=a_in, B=b_in, clear iter_cnt, and move to RUN (busy=1 after that edge).
REQ-013 SHALL ignore start while in RUN or DONE; the operands are not resampled.
REQ-014 SHALL, in RUN, per edge: if A==0, set result=B and go to DONE; else if B==0, set result=A and go to DONE; else if A==B, set result=A and go to DONE; else if A>B, set A=A-B; else set B=B-A.
REQ-015 SHALL increment iter_cnt by 1 on every RUN edge that performs a subtraction, and never on any other edge.
REQ-016 SHALL perform subtraction at WIDTH bits; underflow cannot occur because the smaller value is always subtracted from the larger.
REQ-017 SHALL hold done=1 and busy=0 for exactly the one cycle in DONE, then return to IDLE unconditionally.
REQ-018 SHALL make latency from the accepting edge to done high equal iter_cnt+1 edges.
REQ-019 SHALL define gcd(0,0)=0 and gcd(0,x)=gcd(x,0)=x.
REQ-020 SHALL keep gt/eq/lt at 0 when not busy.
REQ-021 SHALL make back-to-back operation possible with a new start accepted on the edge after DONE, in IDLE, so the minimum gap is one idle cycle.

Reset
REQ-022 SHALL, at any edge with rst_n=0, force state=IDLE, A=B=0, result=0, iter_cnt=0, busy=0, done=0, gt=eq=lt=0, regardless of the current state or start.
REQ-023 SHALL make reset asserted mid-RUN abort the computation with no done pulse; the first start after rst_n rises is accepted normally.
REQ-024 SHALL give reset priority over start when both are asserted on the same edge.

Verification
REQ-025 SHALL test a=12, b=8, start one cycle -> (12,8)->(4,8)->(4,4); done high 3 edges after the accepting edge; result=4; iter_cnt=2; lt seen while (4,8).
REQ-026 SHALL test a=9, b=9 -> done after 1 edge; result=9; iter_cnt=0; eq=1 during RUN.
REQ-027 SHALL test a=0, b=5, then a=0, b=0 -> result=5, then result=0; iter_cnt=0; done 1 edge after each accept.
REQ-028 SHALL test WIDTH=8, a=255, b=1 -> result=1; iter_cnt=254; done 255 edges after the accept; start pulses mid-RUN are ignored.
REQ-029 SHALL test a=200, b=15 with rst_n=0 for one edge after 3 RUN edges -> all outputs 0 next cycle; no done pulse; a following start with a=21, b=14 gives result=7 and iter_cnt=2.
REQ-030 SHALL test start held high continuously with a=6, b=4 -> computations repeat with result=2 each time, separated by exactly one IDLE cycle after each done.
